// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: issues para/compute/ack commands per layer to the conv controller.
// Optional watchdog: define SEQ_TIMEOUT_EN to enable the timeout counter and err flag.
module conv_layer_sequencer #(
  parameter int LAYER_W   = 8,
  parameter int TIMEOUT_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LAYER_W-1:0] layer_num,
  input  logic               reload_para,
  input  logic [3:0]         State,
  input  logic               Next_Reg,
  output logic [3:0]         Control,
  output logic [LAYER_W-1:0] layer_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PARA_REQ,
    S_PARA_WAIT,
    S_PARA_ACK,
    S_COMP_REQ,
    S_COMP_WAIT,
    S_COMP_ACK,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [3:0] C_NONE = 4'b0000;
  localparam logic [3:0] C_PARA = 4'b0001;
  localparam logic [3:0] C_COMP = 4'b0010;
  localparam logic [3:0] C_ACK  = 4'b1111;

  state_t state, state_n;

  logic [LAYER_W-1:0] num_q;
  logic [LAYER_W-1:0] idx_n;
  logic               reload_q;
  logic [3:0]         ctrl_n;
  logic               done_n;
  logic               busy_n;
  logic               accept;
  logic               timeout;

  always_comb begin
    state_n = state;
    idx_n   = layer_idx;
    accept  = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (layer_num != '0) begin
            accept  = 1'b1;
            idx_n   = '0;
            state_n = S_PARA_REQ;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      S_PARA_REQ:  if (State == C_PARA) state_n = S_PARA_WAIT;
      S_PARA_WAIT: if (State == C_ACK)  state_n = S_PARA_ACK;
      S_PARA_ACK:  if (State == C_NONE) state_n = S_COMP_REQ;
      S_COMP_REQ:  if (State == C_COMP) state_n = S_COMP_WAIT;
      S_COMP_WAIT: if (State == C_ACK)  state_n = S_COMP_ACK;
      S_COMP_ACK:  if (Next_Reg)        state_n = S_NEXT;
      S_NEXT: begin
        // one idle cycle on both sides before the next layer's command
        if (State == C_NONE && Control == C_NONE) begin
          if (layer_idx == num_q - LAYER_W'(1)) begin
            state_n = S_DONE;
          end else begin
            idx_n   = layer_idx + LAYER_W'(1);
            state_n = reload_q ? S_PARA_REQ : S_COMP_REQ;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (timeout) begin
      state_n = S_IDLE;
      idx_n   = layer_idx;
    end
    if (state_n == S_DONE) done_n = 1'b1;
  end

  always_comb begin
    ctrl_n = C_NONE;
    unique case (state_n)
      S_PARA_REQ: ctrl_n = C_PARA;
      S_COMP_REQ: ctrl_n = C_COMP;
      S_PARA_ACK: ctrl_n = C_ACK;
      S_COMP_ACK: ctrl_n = C_ACK;
      default:    ctrl_n = C_NONE;
    endcase
    busy_n = (state_n != S_IDLE) && (state_n != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      Control   <= C_NONE;
      layer_idx <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      num_q     <= '0;
      reload_q  <= 1'b0;
    end else begin
      state     <= state_n;
      Control   <= ctrl_n;
      layer_idx <= idx_n;
      busy      <= busy_n;
      done      <= done_n;
      if (accept) begin
        num_q    <= layer_num;
        reload_q <= reload_para;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 err_q;
  logic                 waiting;

  assign waiting = (state != S_IDLE) && (state != S_NEXT) &&
                   (state != S_DONE);
  assign timeout = waiting && (tmo_cnt == '1);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_n != state) tmo_cnt <= '0;
      else if (waiting)     tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
      if (accept)       err_q <= 1'b0;
      else if (timeout) err_q <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Host-side command issuer for the convolution state controller. Drives the 4-bit `Control` command word and watches the returned `State` and `Next_Reg` to run a whole network of `layer_num` layers without software involvement. For each layer it optionally requests a parameter load, then a compute pass, and acknowledges each interrupt state. It sits between the AXI-Lite register file (start / layer count / status) and the convolution state controller.

## Interface
- `LAYER_W`, default 8: width of the layer count and the layer index.
- `TIMEOUT_W`, default 24: width of the watchdog counter. Only used with `SEQ_TIMEOUT_EN`.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a run. Sampled only in IDLE.
- `layer_num` in LAYER_W: number of layers to run. Latched on `start`.
- `reload_para` in 1: 1 = load parameters before every layer; 0 = load only before layer 0. Latched on `start`.
- `State` in 4: controller status. 0000 idle, 0001 para, 0010 compute, 1111 irq.
- `Next_Reg` in 1: one-cycle pulse from the controller when the feature interrupt is acknowledged.
- `Control` out 4: registered command. 0000 none, 0001 para, 0010 compute, 1111 ack.
- `layer_idx` out LAYER_W: index of the layer in progress.
- `busy` out 1: high from `start` acceptance until DONE or ERR.
- `done` out 1: one-cycle pulse when the run completes.
- `err` out 1: sticky timeout flag, cleared by the next accepted `start`. Tied to 0 without `SEQ_TIMEOUT_EN`.

## Operation
- Reset values: `Control`=0000, `layer_idx`=0, `busy`=0, `done`=0, `err`=0, FSM=IDLE.
- IDLE
  - On `start` with `layer_num`≠0: latch the configuration, clear `layer_idx` and `err`, set `busy`, then go to PARA_REQ. If the latched `reload_para` is 0 and the layer is not layer 0, go to COMP_REQ instead.
  - On `start` with `layer_num`=0: pulse `done` in the next cycle and stay in IDLE. `busy` stays 0.
- PARA_REQ: `Control`=0001. Hold it until `State`=0001, then go to PARA_WAIT.
- PARA_WAIT: `Control`=0000. Wait for `State`=1111, then go to PARA_ACK.
- PARA_ACK: `Control`=1111. Hold it until `State`=0000, then go to COMP_REQ.
- COMP_REQ: `Control`=0010. Hold it until `State`=0010, then go to COMP_WAIT.
- COMP_WAIT: `Control`=0000. Wait for `State`=1111, then go to COMP_ACK.
- COMP_ACK: `Control`=1111. Hold it until `Next_Reg`=1, then go to NEXT.
- NEXT
  - Requires `State`=0000 and `Control`=0000 for one cycle before leaving.
  - If `layer_idx`=`layer_num`−1: go to DONE.
  - Otherwise increment `layer_idx` and go to PARA_REQ, or to COMP_REQ when the latched `reload_para`=0.
- DONE: pulse `done` for one cycle, clear `busy`, return to IDLE. `layer_idx` keeps its final value.
- `start` outside IDLE is ignored.
- `State` values not expected in the current state are ignored; the FSM keeps waiting.

## Timing
- `Control` is registered and changes on the clock edge after the FSM enters a state.
- Latency from `start` to `Control`=0001 is 1 cycle.
- Command hold is level-based: `Control` stays on the command until the matching `State` is seen. This covers the controller's one-cycle registered `State` lag.
- `Control` returns to 0000 on the edge after acceptance. The controller never sees a repeated command while it is back in idle.
- NEXT inserts at least one cycle of `Control`=0000 between the ack and the next command.
- `rst` asserted mid-run returns every output to its reset value on the next edge. Any in-flight command is abandoned; the controller is reset by the same `rst`.
- `layer_idx` wrap: `layer_num` up to 2^LAYER_W−1 is supported, so the index never wraps.

## Configuration
- `SEQ_TIMEOUT_EN`
  - Defined:
    - A TIMEOUT_W-bit counter clears on every FSM state change and increments while in any *_REQ, *_WAIT or *_ACK state.
    - When the counter reaches all-ones: set `err`, drive `Control`=0000, clear `busy`, go to IDLE. `done` is not pulsed.
  - Undefined: no counter, `err` is constant 0, and the FSM waits indefinitely.

## Test plan
- Three layers, reload on: `layer_num`=3, `reload_para`=1, controller model responds in 2–5 cycles → Control sequence (0001, 0000, 1111, 0010, 0000, 1111) ×3; `layer_idx` goes 0,1,2; one `done` pulse; `busy` falls on the same edge.
- Reload off: `layer_num`=2, `reload_para`=0 → exactly one 0001 command (layer 0), two 0010 commands, `done` once.
- Zero layers: `layer_num`=0 with `start` → `done` pulses 1 cycle later, `Control` never leaves 0000, `busy` stays 0.
- Slow acceptance: model delays `State`=0001 by 20 cycles → `Control` holds 0001 for all 20 cycles, then 0000 on the next edge.
- Mid-run reset: `rst` asserted in COMP_WAIT of layer 1 → next cycle `Control`=0000, `layer_idx`=0, `busy`=0; a fresh `start` runs cleanly.
- With `SEQ_TIMEOUT_EN` and `TIMEOUT_W`=4: model never returns `State`=1111 → `err`=1 after 15 cycles in PARA_WAIT, `busy`=0, no `done`; the next `start` clears `err`.
